tcdm_master_port: RTL and testbench
===================================

# tcdm_master_port

Per-master front-end stage that feeds one input port of the TCDM full crossbar. It converts a core-side valid/ready request stream into the crossbar's req/gnt protocol through a one-entry request register. Fixed-latency crossbar responses are captured in a response FIFO, so the core may stall responses without loss. A credit counter stops the block from issuing a request whose response the FIFO could not hold.

## Interface
- NumOut, 4: crossbar output (bank) count; power of two, ≥2.
- ReqDataWidth, 32: write data width.
- RespDataWidth, 32: read data width.
- RespLat, 1: crossbar response latency in cycles; must equal the crossbar setting.
- RespDepth, 4: response FIFO entries, ≥1; also the credit limit.
- WriteRespOn, 1'b1: must equal the crossbar setting; 1 means writes return a response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low. One clock.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  core request accepted when valid&&ready.
- req_add_i  in  $clog2(NumOut)  bank index.
- req_wen_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  ReqDataWidth  write data.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  core pops response.
- resp_rdata_o  out  RespDataWidth  response data.
- xbar_req_o  out  1  to crossbar req_i.
- xbar_add_o  out  $clog2(NumOut)  to crossbar add_i.
- xbar_wen_o  out  1  to crossbar wen_i.
- xbar_wdata_o  out  ReqDataWidth  to crossbar wdata_i.
- xbar_gnt_i  in  1  from crossbar gnt_o.
- xbar_vld_i  in  1  from crossbar vld_o.
- xbar_rdata_i  in  RespDataWidth  from crossbar rdata_o.

## Operation
- Request register: fields valid, add, wen, wdata. Loads on req_valid_i&&req_ready_o.
- req_ready_o = !reg_valid || issue. This path from xbar_gnt_i is combinational.
- needs_resp = !reg_wen || WriteRespOn.
- issue_ok = !needs_resp || (credits < RespDepth).
- xbar_req_o = reg_valid && issue_ok. xbar_add/wen/wdata_o always drive the register contents.
- issue = xbar_req_o && xbar_gnt_i. When issue occurs and no new load happens, reg_valid clears.
- Credits, width $clog2(RespDepth+1), count granted-but-unreturned responses plus FIFO occupancy.
  - +1 on issue&&needs_resp.
  - −1 on resp_valid_o&&resp_ready_i.
  - Both in the same cycle: no change.
- Response FIFO depth RespDepth. It pushes xbar_rdata_i whenever xbar_vld_i=1.
- resp_valid_o = FIFO non-empty; resp_rdata_o = head entry. Order is preserved: crossbar responses are in-order for a single master.
- Push to a full FIFO is impossible by construction. A simulation assertion fires if xbar_vld_i=1 while the FIFO is full and no pop occurs.
- Push and pop in the same cycle at full or empty occupancy are legal. Occupancy stays unchanged, and at empty the new data appears on the next cycle (no bypass).
- Once xbar_req_o rises, register contents are held stable until issue. xbar_req_o does not drop while the register is valid and credits are unchanged.

## Timing
- Reset values (async assert): reg_valid=0, credits=0, FIFO empty.
  - Outputs: xbar_req_o=0, xbar_add_o=0, xbar_wen_o=0, xbar_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, req_ready_o=1.
- Reset mid-operation discards the register, all credits and all FIFO data. Crossbar responses still in flight after reset release are not expected; the crossbar is reset together with this block.
- Core handshake at cycle t → xbar_req_o at t+1 → grant at t+1 (best case) → xbar_vld_i at t+1+RespLat → resp_valid_o at t+2+RespLat.
- Full throughput (one request per cycle) requires RespDepth ≥ RespLat+2 with resp_ready_i held at 1. Smaller depths are legal but throttle issue.
- Writes with WriteRespOn=0 consume no credit and never stall on the credit limit.

## Test plan
- Reset: assert rst_ni=0 mid-burst → all outputs at reset values within the same cycle; req_ready_o=1 after release.
- Single read (RespLat=1): load add=3 at cycle 0 with xbar_gnt_i=1; crossbar returns 0xCAFE_F00D at cycle 2 → xbar_req_o=1 with xbar_add_o=3 at cycle 1; resp_valid_o=1 with resp_rdata_o=0xCAFE_F00D at cycle 3.
- Grant stall: xbar_gnt_i=0 for 3 cycles with wdata=0x1234 and wen=1 → xbar_req_o, xbar_add_o and xbar_wdata_o stable and req_ready_o=0 for those 3 cycles; issue happens on the 4th cycle.
- Credit limit (RespDepth=2, resp_ready_i=0): stream 4 reads with gnt=1 → exactly 2 issued, then xbar_req_o=0. Raise resp_ready_i → responses popped in order; remaining reads issue one cycle after each pop.
- Simultaneous pop and grant at credits=RespDepth-1 → credits unchanged; continuous stream at 1 request per cycle with RespDepth=3, RespLat=1.
- WriteRespOn=0, resp_ready_i=0: 6 back-to-back writes → all issued on consecutive cycles, resp_valid_o stays 0, credits stay 0.

Source files
------------

// File: rtl/tcdm_master_port.sv
// Per-master TCDM crossbar front end: one-entry request slot, credit-gated issue
// and an in-order response FIFO sized to the credit limit.

module tcdm_master_port #(
    parameter int unsigned NumOut        = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter int unsigned RespDepth     = 4,
    parameter logic        WriteRespOn   = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [$clog2(NumOut)-1:0]    req_add_i,
    input  logic                         req_wen_i,
    input  logic [ReqDataWidth-1:0]      req_wdata_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [RespDataWidth-1:0]     resp_rdata_o,
    output logic                         xbar_req_o,
    output logic [$clog2(NumOut)-1:0]    xbar_add_o,
    output logic                         xbar_wen_o,
    output logic [ReqDataWidth-1:0]      xbar_wdata_o,
    input  logic                         xbar_gnt_i,
    input  logic                         xbar_vld_i,
    input  logic [RespDataWidth-1:0]     xbar_rdata_i
);

    localparam int unsigned AddrWidth = $clog2(NumOut);
    localparam int unsigned CntWidth  = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth  = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam logic [CntWidth-1:0] DepthVal = CntWidth'(RespDepth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RespDepth - 1);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        logic [PtrWidth-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrWidth'(1);
        end
        return nxt;
    endfunction

    logic                     req_valid_q, req_valid_d;
    logic [AddrWidth-1:0]     req_add_q, req_add_d;
    logic                     req_wen_q, req_wen_d;
    logic [ReqDataWidth-1:0]  req_wdata_q, req_wdata_d;
    logic [CntWidth-1:0]      credits_q, credits_d;
    logic [CntWidth-1:0]      fill_q, fill_d;
    logic [PtrWidth-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RespDataWidth-1:0] fifo_mem_q [RespDepth];

    logic needs_resp_s, issue_ok_s, issue_s, load_s;
    logic credit_inc_s, push_s, pop_s, fifo_full_s;

    // A slot holding a store with write responses disabled never waits on credits.
    assign needs_resp_s = !req_wen_q || WriteRespOn;
    assign issue_ok_s   = !needs_resp_s || (credits_q < DepthVal);
    assign xbar_req_o   = req_valid_q && issue_ok_s;
    assign issue_s      = xbar_req_o && xbar_gnt_i;
    assign req_ready_o  = !req_valid_q || issue_s;
    assign load_s       = req_valid_i && req_ready_o;
    assign credit_inc_s = issue_s && needs_resp_s;

    assign xbar_add_o   = req_add_q;
    assign xbar_wen_o   = req_wen_q;
    assign xbar_wdata_o = req_wdata_q;

    assign push_s       = xbar_vld_i;
    assign resp_valid_o = (fill_q != '0);
    assign pop_s        = resp_valid_o && resp_ready_i;
    assign fifo_full_s  = (fill_q == DepthVal);
    assign resp_rdata_o = fifo_mem_q[rd_ptr_q];

    // Request slot next state: a load wins over the clear caused by issue.
    always_comb begin
        req_valid_d = req_valid_q;
        req_add_d   = req_add_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        if (load_s) begin
            req_valid_d = 1'b1;
            req_add_d   = req_add_i;
            req_wen_d   = req_wen_i;
            req_wdata_d = req_wdata_i;
        end else if (issue_s) begin
            req_valid_d = 1'b0;
        end else begin
            req_valid_d = req_valid_q;
        end
    end

    // Credit counter: outstanding responses plus FIFO occupancy.
    always_comb begin
        credits_d = credits_q;
        case ({credit_inc_s, pop_s})
            2'b10:   credits_d = credits_q + CntWidth'(1);
            2'b01:   credits_d = credits_q - CntWidth'(1);
            default: credits_d = credits_q;
        endcase
    end

    // FIFO fill level and pointers; no bypass, so a push into empty shows next cycle.
    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + CntWidth'(1);
            2'b01:   fill_d = fill_q - CntWidth'(1);
            default: fill_d = fill_q;
        endcase
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_q <= 1'b0;
            req_add_q   <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            credits_q   <= '0;
            fill_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_add_q   <= req_add_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            credits_q   <= credits_d;
            fill_q      <= fill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Response storage, cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RespDepth); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= xbar_rdata_i;
        end
    end

    tcdm_master_port_chk #(
        .RespLat (RespLat)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .full_i       (fifo_full_s),
        .issue_resp_i (credit_inc_s)
    );

endmodule

// Protocol checks: no push into a full FIFO, and every response lines up
// with an issue exactly RespLat cycles earlier.
module tcdm_master_port_chk #(
    parameter int unsigned RespLat = 1
) (
    input logic clk_i,
    input logic rst_ni,
    input logic push_i,
    input logic pop_i,
    input logic full_i,
    input logic issue_resp_i
);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_i && !pop_i));

    a_resp_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i |-> $past(issue_resp_i, RespLat));

endmodule

// File: tb/tb_tcdm_master_port.sv
// Directed bench: two port instances (depth 2 with write responses, depth 3
// without) driven by a shared core stream and checked against a queue model.

module tb_tcdm_master_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        req_valid;
    logic [1:0]  req_add;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        gnt;

    logic [1:0]  req_ready, resp_valid, xbar_req, xbar_wen, xbar_vld;
    logic [31:0] resp_rdata [2];
    logic [1:0]  xbar_add   [2];
    logic [31:0] xbar_wdata [2];
    logic [31:0] xbar_rdata [2];

    tcdm_master_port #(
        .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
        .RespLat(1), .RespDepth(2), .WriteRespOn(1'b1)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_add_i(req_add), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata[0]),
        .xbar_req_o(xbar_req[0]), .xbar_add_o(xbar_add[0]), .xbar_wen_o(xbar_wen[0]),
        .xbar_wdata_o(xbar_wdata[0]), .xbar_gnt_i(gnt),
        .xbar_vld_i(xbar_vld[0]), .xbar_rdata_i(xbar_rdata[0])
    );

    tcdm_master_port #(
        .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
        .RespLat(1), .RespDepth(3), .WriteRespOn(1'b0)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_add_i(req_add), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata[1]),
        .xbar_req_o(xbar_req[1]), .xbar_add_o(xbar_add[1]), .xbar_wen_o(xbar_wen[1]),
        .xbar_wdata_o(xbar_wdata[1]), .xbar_gnt_i(gnt),
        .xbar_vld_i(xbar_vld[1]), .xbar_rdata_i(xbar_rdata[1])
    );

    int          dep [2];
    logic        wro [2];
    logic        m_valid [2];
    logic [1:0]  m_add   [2];
    logic        m_wen   [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_fifo  [2][8];
    int          m_cnt   [2];
    logic        m_ret   [2];
    logic [31:0] m_retd  [2];
    logic [31:0] xdata   [2];
    int          total;
    int          bad;

    task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_add[k]   = 2'd0;
            m_wen[k]   = 1'b0;
            m_wdata[k] = 32'd0;
            m_cnt[k]   = 0;
            m_ret[k]   = 1'b0;
            m_retd[k]  = 32'd0;
        end
    endtask

    // Credits are returns still in flight plus responses waiting in the FIFO.
    task automatic model_cycle(input int k);
        int   cr;
        logic needs, xreq, iss, rdy, rv;
        cr    = m_cnt[k] + (m_ret[k] ? 1 : 0);
        needs = !m_wen[k] || wro[k];
        xreq  = m_valid[k] && (!needs || (cr < dep[k]));
        iss   = xreq && gnt;
        rdy   = !m_valid[k] || iss;
        rv    = (m_cnt[k] > 0);
        cmp("xbar_req", k, 32'(xbar_req[k]), 32'(xreq));
        cmp("req_ready", k, 32'(req_ready[k]), 32'(rdy));
        cmp("resp_valid", k, 32'(resp_valid[k]), 32'(rv));
        cmp("xbar_add", k, 32'(xbar_add[k]), 32'(m_add[k]));
        cmp("xbar_wen", k, 32'(xbar_wen[k]), 32'(m_wen[k]));
        cmp("xbar_wdata", k, xbar_wdata[k], m_wdata[k]);
        if (rv) begin
            cmp("resp_rdata", k, resp_rdata[k], m_fifo[k][0]);
        end
        if (rv && resp_ready) begin
            for (int i = 0; i < 7; i++) begin
                m_fifo[k][i] = m_fifo[k][i+1];
            end
            m_cnt[k]--;
        end
        if (m_ret[k]) begin
            m_fifo[k][m_cnt[k]] = m_retd[k];
            m_cnt[k]++;
        end
        if (iss && needs) begin
            m_ret[k]  = 1'b1;
            m_retd[k] = xdata[k];
            xdata[k]  = xdata[k] + 32'h0001_0001;
        end else begin
            m_ret[k] = 1'b0;
        end
        if (req_valid && rdy) begin
            m_valid[k] = 1'b1;
            m_add[k]   = req_add;
            m_wen[k]   = req_wen;
            m_wdata[k] = req_wdata;
        end else if (iss) begin
            m_valid[k] = 1'b0;
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later.
    task automatic step(input logic rv, input logic [1:0] ad, input logic we,
                        input logic [31:0] wd, input logic rr, input logic g);
        @(negedge clk);
        req_valid  = rv;
        req_add    = ad;
        req_wen    = we;
        req_wdata  = wd;
        resp_ready = rr;
        gnt        = g;
        for (int k = 0; k < 2; k++) begin
            xbar_vld[k]   = m_ret[k];
            xbar_rdata[k] = m_ret[k] ? m_retd[k] : 32'hDEAD_BEEF;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            model_cycle(k);
        end
    endtask

    task automatic chk_reset_vals();
        for (int k = 0; k < 2; k++) begin
            cmp("rst_xbar_req", k, 32'(xbar_req[k]), 32'd0);
            cmp("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
            cmp("rst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
            cmp("rst_resp_rdata", k, resp_rdata[k], 32'd0);
            cmp("rst_xbar_add", k, 32'(xbar_add[k]), 32'd0);
            cmp("rst_xbar_wen", k, 32'(xbar_wen[k]), 32'd0);
            cmp("rst_xbar_wdata", k, xbar_wdata[k], 32'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        dep[0] = 2; wro[0] = 1'b1;
        dep[1] = 3; wro[1] = 1'b0;
        xdata[0] = 32'h1000_0000;
        xdata[1] = 32'h2000_0000;
        rst_ni = 1'b0;
        req_valid = 1'b0; req_add = 2'd0; req_wen = 1'b0; req_wdata = 32'd0;
        resp_ready = 1'b1; gnt = 1'b1;
        xbar_vld = 2'b00;
        xbar_rdata[0] = 32'd0; xbar_rdata[1] = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Single read of bank 3 returning CAFEF00D.
        xdata[0] = 32'hCAFE_F00D;
        xdata[1] = 32'hCAFE_F00D;
        step(1'b1, 2'd3, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        cmp("rd_xbar_req_c1", 0, 32'(xbar_req[0]), 32'd1);
        cmp("rd_xbar_add_c1", 0, 32'(xbar_add[0]), 32'd3);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        cmp("rd_resp_valid_c3", 0, 32'(resp_valid[0]), 32'd1);
        cmp("rd_resp_rdata_c3", 0, resp_rdata[0], 32'hCAFE_F00D);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Grant stall on a store: slot held for three cycles, issue on the fourth.
        step(1'b1, 2'd1, 1'b1, 32'h0000_1234, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd2, 1'b1, 32'h0000_5555, 1'b1, 1'b0);
            cmp("stall_xbar_req", 0, 32'(xbar_req[0]), 32'd1);
            cmp("stall_xbar_add", 0, 32'(xbar_add[0]), 32'd1);
            cmp("stall_xbar_wdata", 0, xbar_wdata[0], 32'h0000_1234);
            cmp("stall_req_ready", 0, 32'(req_ready[0]), 32'd0);
        end
        step(1'b1, 2'd2, 1'b1, 32'h0000_5555, 1'b1, 1'b1);
        cmp("stall_release_ready", 0, 32'(req_ready[0]), 32'd1);
        repeat (4) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Credit limit with responses held back.
        xdata[0] = 32'hA000_0000;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'(i), 1'b0, 32'(i), 1'b0, 1'b1);
        end
        cmp("credit_block_req", 0, 32'(xbar_req[0]), 32'd0);
        cmp("credit_block_ready", 0, 32'(req_ready[0]), 32'd0);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        cmp("credit_pop0_rdata", 0, resp_rdata[0], 32'hA000_0000);
        cmp("credit_pop0_req", 0, 32'(xbar_req[0]), 32'd0);
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        cmp("credit_pop1_rdata", 0, resp_rdata[0], 32'hA001_0001);
        cmp("credit_reissue_req", 0, 32'(xbar_req[0]), 32'd1);
        repeat (8) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Back-to-back reads with responses consumed every cycle.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'(i), 1'b0, 32'(i), 1'b1, 1'b1);
            cmp("stream_ready", 1, 32'(req_ready[1]), 32'd1);
            if (i > 0) begin
                cmp("stream_xbar_req", 1, 32'(xbar_req[1]), 32'd1);
            end
        end
        repeat (5) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Stores without write responses never consume credit.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'(i), 1'b1, 32'h0000_00B0 + 32'(i), 1'b0, 1'b1);
            cmp("wr_ready", 1, 32'(req_ready[1]), 32'd1);
            cmp("wr_resp_valid", 1, 32'(resp_valid[1]), 32'd0);
            if (i > 0) begin
                cmp("wr_xbar_req", 1, 32'(xbar_req[1]), 32'd1);
            end
        end
        repeat (2) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        cmp("wr_resp_valid_end", 1, 32'(resp_valid[1]), 32'd0);

        // Reset in the middle of a read burst.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'(i), 1'b0, 32'd0, 1'b0, 1'b1);
        end
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        xbar_vld  = 2'b00;
        rst_ni    = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        cmp("post_rst_ready", 0, 32'(req_ready[0]), 32'd1);
        cmp("post_rst_ready", 1, 32'(req_ready[1]), 32'd1);
        step(1'b1, 2'd2, 1'b0, 32'd0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
